uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Parametrised UART transmitter with an integrated transmit FIFO, runtime-configurable word length, parity and stop bits. The host writes words into the FIFO at full clock rate. The serialiser drains the FIFO back-to-back into frames on `tx`, with a frame-aligned baud counter. It replaces the single-word, handshake-gated transmitter in the peripheral UART path and sits between the bus register file and the pin mux.

## Interface
- `DATA_W`, 16: maximum data bits per word; width of `data_in`.
- `FIFO_DEPTH`, 8: FIFO entries. Must be a power of two and ≥ 2.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low (0 = reset).
- `data_in`  in  DATA_W  word to queue. Bit 0 is sent first.
- `wr_en`  in  1  one-cycle write strobe, level-sampled every cycle.
- `clk_div`  in  16  bit period in clk cycles. A value of 0 is treated as 1.
- `bits_per_word`  in  5  number of data bits, legal range 1..DATA_W. A value of 0 is treated as 1; values above DATA_W are treated as DATA_W.
- `parity_mode`  in  2  00 none, 01 even, 10 odd, 11 none.
- `two_stop`  in  1  1 selects two stop bits, 0 selects one.
- `tx`  out  1  serial line, idles high.
- `busy`  out  1  high while a frame is in progress or the FIFO is non-empty.
- `full`  out  1  FIFO holds FIFO_DEPTH words.
- `empty`  out  1  FIFO holds 0 words.
- `level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- `overflow`  out  1  one-cycle pulse when a write is dropped.
- `frame_done`  out  1  one-cycle pulse at the end of the last stop bit.

## Operation
- Reset values: `tx`=1, `busy`=0, `full`=0, `empty`=1, `level`=0, `overflow`=0, `frame_done`=0. The FSM resets to IDLE and the baud counter to 0.
- Reset asserted mid-frame: `tx` returns to 1 immediately (asynchronously). FIFO contents are discarded.
- FIFO write rule:
  - When `wr_en`=1 and `full`=0, `data_in` is stored and `level` increments.
  - When `wr_en`=1 and `full`=1, the word is dropped and `overflow` pulses on the next cycle.
  - `full` is evaluated before any pop in the same cycle, so a write to a full FIFO is dropped even if a pop happens that cycle.
  - A simultaneous write and pop on a non-full FIFO leaves `level` unchanged.
- Pointers: read and write pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. `level` is a separate counter.
- FSM states: IDLE → START → DATA → PARITY (skipped when there is no parity) → STOP → IDLE, or back to START.
  - IDLE: if `empty`=0, pop the head word into the shift register, latch config, and drive `tx`=0 from the next edge. Next state is START.
  - START: hold `tx`=0 for one bit period.
  - DATA: send `bits_per_word` bits, LSB first, one bit period each.
  - PARITY: send the XOR of the sent data bits for even parity, or its inverse for odd parity.
  - STOP: hold `tx`=1 for one bit period, or two when `two_stop`=1. At the final bit-period boundary, pulse `frame_done`. If the FIFO is non-empty, pop and go straight to START (`tx` falls on that same edge, with no idle gap); otherwise go to IDLE.
- Latched config: `clk_div`, `bits_per_word`, `parity_mode` and `two_stop` are latched at each pop. Changes mid-frame take effect at the next frame.
- Baud counter: a 16-bit counter reloads to 0 at every pop and counts to latched `clk_div`-1, giving a one-cycle bit tick every `clk_div` cycles. It is frame-aligned, not free-running.
- `busy` = (state ≠ IDLE) | ~`empty`.

## Timing
- Write latency: a write captured at edge E0 into an idle, empty block causes `empty`=0 after E0. The pop occurs at E1 and `tx`=0 after E1.
- Every bit, including start, parity and stop bits, lasts exactly max(`clk_div`,1) cycles.
- Frame length in cycles is div × (1 + n + p + s), where div = max(`clk_div`,1), n = data bits, p = 1 if parity else 0, s = 1 or 2.
- Back-to-back frames have zero idle cycles between the last stop bit and the next start bit.
- `frame_done` and the next pop occur on the same edge.
- `level`, `full` and `empty` update on the edge following the write or pop.

## Test plan
- Single word, 8N1: `clk_div`=4, `bits_per_word`=8, no parity, one stop bit, write 0x0A5. Line shows start bit, then 1,0,1,0,0,1,0,1, then stop bit, each bit 4 cycles, 40 cycles total. `frame_done` pulses once; `busy` drops the cycle after.
- Parity: `clk_div`=2, 7 data bits, write 0x03. With even parity the parity bit is 0; with odd parity it is 1. With 16 data bits (DATA_W=16), write 0xFFFF: every data bit is 1 and the even parity bit is 0.
- Two stop bits with `clk_div`=0: 1-cycle bits. A 5-bit word with two stop bits gives an 8-cycle frame. `tx` is high for 2 cycles at the end.
- FIFO fill and overflow: hold the serialiser with a large `clk_div`, write 10 words to FIFO_DEPTH=8. The first pop frees one slot, so 9 words are accepted. `full`=1 and `level`=8 after the ninth write; the tenth write is dropped and `overflow` pulses once. All 9 words then go out in order with no inter-frame gap; `empty`=1 and `busy`=0 at the end.
- Simultaneous write and pop at `level`=3 leaves `level`=3, and data order is preserved across pointer wrap after 20 words.
- Reset mid-DATA: drive `rst`=0 during bit 3. `tx`=1 with no clock edge needed, FIFO is empty, and after release the block is idle with no spurious frame.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by an internal transmit FIFO.
// The host pushes words at full clock rate. The serialiser pops them into
// frames back-to-back with a frame-aligned baud counter. Word length,
// parity, stop bits and bit period are latched per frame at pop time.
module uart_tx_fifo #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             data_in,
    input  logic                          wr_en,
    input  logic [15:0]                   clk_div,
    input  logic [4:0]                    bits_per_word,
    input  logic [1:0]                    parity_mode,
    input  logic                          two_stop,
    output logic                          tx,
    output logic                          busy,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic                          frame_done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] DEPTH_L  = LVL_W'(FIFO_DEPTH);
    localparam logic [5:0]       DATA_W_L = 6'(DATA_W);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Parity bit is present only for modes 01 (even) and 10 (odd).
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == 2'b01) || (mode == 2'b10);
    endfunction

    // acc is the XOR of all sent data bits; odd parity inverts it.
    function automatic logic parity_bit(input logic acc, input logic [1:0] mode);
        return acc ^ (mode == 2'b10);
    endfunction

    // FIFO storage and control
    logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [LVL_W-1:0]  level_r;
    logic [LVL_W-1:0]  level_next_s;
    logic              full_r;
    logic              empty_r;
    logic              overflow_r;
    logic              push_s;
    logic              pop_s;

    // Serialiser state
    state_t            state_r;
    state_t            state_next_s;
    logic [15:0]       baud_cnt_r;
    logic [15:0]       baud_cnt_next_s;
    logic              tick_s;
    logic [DATA_W-1:0] shift_r;
    logic [DATA_W-1:0] shift_next_s;
    logic              par_r;
    logic              par_next_s;
    logic [5:0]        bit_cnt_r;
    logic [5:0]        bit_cnt_next_s;
    logic              stop_cnt_r;
    logic              stop_cnt_next_s;
    logic              tx_r;
    logic              tx_next_s;
    logic              frame_done_r;
    logic              frame_done_next_s;
    logic              busy_r;

    // Per-frame configuration
    logic [15:0]       div_r;
    logic [15:0]       div_sane_s;
    logic [5:0]        n_r;
    logic [5:0]        n_sane_s;
    logic [1:0]        pmode_r;
    logic              two_stop_r;

    // A write is accepted only when the FIFO was not full at the start of the cycle.
    assign push_s = wr_en & ~full_r;
    assign tick_s = (baud_cnt_r == (div_r - 16'd1));

    // Clamp runtime configuration into its legal range before latching.
    always_comb begin
        div_sane_s = clk_div;
        n_sane_s   = {1'b0, bits_per_word};
        if (clk_div == 16'd0) begin
            div_sane_s = 16'd1;
        end else begin
            div_sane_s = clk_div;
        end
        if (bits_per_word == 5'd0) begin
            n_sane_s = 6'd1;
        end else if ({1'b0, bits_per_word} > DATA_W_L) begin
            n_sane_s = DATA_W_L;
        end else begin
            n_sane_s = {1'b0, bits_per_word};
        end
    end

    // Next FIFO occupancy from this cycle's push and pop.
    always_comb begin
        level_next_s = level_r;
        case ({push_s, pop_s})
            2'b10:   level_next_s = level_r + LVL_W'(1);
            2'b01:   level_next_s = level_r - LVL_W'(1);
            default: level_next_s = level_r;
        endcase
    end

    // FIFO data array; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= data_in;
        end
    end

    // FIFO pointers, occupancy and status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            level_r    <= '0;
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            level_r    <= level_next_s;
            full_r     <= (level_next_s == DEPTH_L);
            empty_r    <= (level_next_s == LVL_W'(0));
            overflow_r <= wr_en & full_r;
        end
    end

    // Serialiser next-state, line value and datapath updates.
    always_comb begin
        state_next_s      = state_r;
        pop_s             = 1'b0;
        tx_next_s         = tx_r;
        shift_next_s      = shift_r;
        par_next_s        = par_r;
        bit_cnt_next_s    = bit_cnt_r;
        stop_cnt_next_s   = stop_cnt_r;
        frame_done_next_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty_r) begin
                    pop_s        = 1'b1;
                    state_next_s = ST_START;
                    tx_next_s    = 1'b0;
                end else begin
                    tx_next_s    = 1'b1;
                end
            end
            ST_START: begin
                if (tick_s) begin
                    state_next_s   = ST_DATA;
                    tx_next_s      = shift_r[0];
                    shift_next_s   = shift_r >> 1;
                    par_next_s     = par_r ^ shift_r[0];
                    bit_cnt_next_s = 6'd1;
                end else begin
                    state_next_s   = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    if (bit_cnt_r >= n_r) begin
                        if (parity_enabled(pmode_r)) begin
                            state_next_s    = ST_PARITY;
                            tx_next_s       = parity_bit(par_r, pmode_r);
                        end else begin
                            state_next_s    = ST_STOP;
                            tx_next_s       = 1'b1;
                            stop_cnt_next_s = 1'b0;
                        end
                    end else begin
                        tx_next_s      = shift_r[0];
                        shift_next_s   = shift_r >> 1;
                        par_next_s     = par_r ^ shift_r[0];
                        bit_cnt_next_s = bit_cnt_r + 6'd1;
                    end
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (tick_s) begin
                    state_next_s    = ST_STOP;
                    tx_next_s       = 1'b1;
                    stop_cnt_next_s = 1'b0;
                end else begin
                    state_next_s    = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (tick_s) begin
                    if (two_stop_r && !stop_cnt_r) begin
                        stop_cnt_next_s = 1'b1;
                    end else begin
                        frame_done_next_s = 1'b1;
                        // Chain straight into the next frame when data is waiting.
                        if (!empty_r) begin
                            pop_s        = 1'b1;
                            state_next_s = ST_START;
                            tx_next_s    = 1'b0;
                        end else begin
                            state_next_s = ST_IDLE;
                            tx_next_s    = 1'b1;
                        end
                    end
                end else begin
                    state_next_s = ST_STOP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                tx_next_s    = 1'b1;
            end
        endcase
        if (pop_s) begin
            shift_next_s    = mem_r[rd_ptr_r];
            par_next_s      = 1'b0;
            bit_cnt_next_s  = 6'd0;
            stop_cnt_next_s = 1'b0;
        end else begin
            shift_next_s    = shift_next_s;
        end
    end

    // Frame-aligned baud counter: restarts at every pop, wraps on each bit tick.
    always_comb begin
        baud_cnt_next_s = baud_cnt_r;
        if (pop_s) begin
            baud_cnt_next_s = 16'd0;
        end else if (state_r == ST_IDLE) begin
            baud_cnt_next_s = 16'd0;
        end else if (tick_s) begin
            baud_cnt_next_s = 16'd0;
        end else begin
            baud_cnt_next_s = baud_cnt_r + 16'd1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Serialiser datapath and configuration latched at pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baud_cnt_r <= 16'd0;
            shift_r    <= '0;
            par_r      <= 1'b0;
            bit_cnt_r  <= 6'd0;
            stop_cnt_r <= 1'b0;
            div_r      <= 16'd1;
            n_r        <= 6'd1;
            pmode_r    <= 2'b00;
            two_stop_r <= 1'b0;
        end else begin
            baud_cnt_r <= baud_cnt_next_s;
            shift_r    <= shift_next_s;
            par_r      <= par_next_s;
            bit_cnt_r  <= bit_cnt_next_s;
            stop_cnt_r <= stop_cnt_next_s;
            if (pop_s) begin
                div_r      <= div_sane_s;
                n_r        <= n_sane_s;
                pmode_r    <= parity_mode;
                two_stop_r <= two_stop;
            end
        end
    end

    // Registered line and status outputs; tx idles high and returns high on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_r         <= 1'b1;
            frame_done_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            tx_r         <= tx_next_s;
            frame_done_r <= frame_done_next_s;
            busy_r       <= (state_next_s != ST_IDLE) || (level_next_s != LVL_W'(0));
        end
    end

    assign tx         = tx_r;
    assign busy       = busy_r;
    assign full       = full_r;
    assign empty      = empty_r;
    assign level      = level_r;
    assign overflow   = overflow_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a frame table, FIFO fill/overflow,
// simultaneous push/pop with pointer wrap, and reset mid-frame. A line
// monitor decodes every frame against a queue of expected words.
module tb_uart_tx_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data_in;
    logic        wr_en;
    logic [15:0] clk_div;
    logic [4:0]  bits_per_word;
    logic [1:0]  parity_mode;
    logic        two_stop;
    logic        tx;
    logic        busy;
    logic        full;
    logic        empty;
    logic [3:0]  level;
    logic        overflow;
    logic        frame_done;

    uart_tx_fifo #(.DATA_W(16), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .wr_en(wr_en),
        .clk_div(clk_div), .bits_per_word(bits_per_word),
        .parity_mode(parity_mode), .two_stop(two_stop),
        .tx(tx), .busy(busy), .full(full), .empty(empty), .level(level),
        .overflow(overflow), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        int          n;
        logic [1:0]  pmode;
        logic        two;
        int          div;
    } exp_t;

    typedef struct {
        logic [15:0] div;
        logic [4:0]  bpw;
        logic [1:0]  pmode;
        logic        two;
        logic [15:0] data;
        int          exp_len;
        logic        exp_par;
    } vec_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    logic mon_busy    = 1'b0;
    logic b2b_chk     = 1'b0;
    logic last_par    = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int eff_n(input logic [4:0] b);
        if (b == 5'd0) return 1;
        if (b > 5'd16) return 16;
        return int'(b);
    endfunction

    function automatic int eff_div(input logic [15:0] d);
        if (d == 16'd0) return 1;
        return int'(d);
    endfunction

    function automatic logic has_par(input logic [1:0] m);
        return (m == 2'b01) || (m == 2'b10);
    endfunction

    // Expected bit b of a frame: start, data LSB first, optional parity, stops.
    function automatic logic frame_bit(input exp_t e, input int b);
        logic acc;
        if (b == 0) return 1'b0;
        if (b <= e.n) return e.data[b-1];
        if (b == e.n + 1 && has_par(e.pmode)) begin
            acc = 1'b0;
            for (int i = 0; i < e.n; i++) acc = acc ^ e.data[i];
            return (e.pmode == 2'b10) ? ~acc : acc;
        end
        return 1'b1;
    endfunction

    task automatic write_word(input logic [15:0] d, input logic accept);
        exp_t e;
        data_in = d;
        wr_en   = 1'b1;
        if (accept) begin
            e.data  = d;
            e.n     = eff_n(bits_per_word);
            e.pmode = parity_mode;
            e.two   = two_stop;
            e.div   = eff_div(clk_div);
            sb.push_back(e);
        end
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int c = 0;
        while ((sb.size() != 0 || mon_busy) && c < limit) begin
            tick();
            c++;
        end
        check("drain_timeout", (c >= limit) ? 32'd1 : 32'd0, 32'd0);
    endtask

    // Line monitor: decode each frame, compare to the scoreboard head.
    initial begin : monitor
        exp_t        e;
        int          errs;
        int          nb;
        bit          aborted;
        logic [16:0] mask;
        logic [15:0] got;
        logic        eb;
        forever begin
            if (rst === 1'b1 && tx === 1'b0) begin
                mon_busy = 1'b1;
                if (sb.size() == 0) begin
                    check("spurious_frame", 32'd1, 32'd0);
                    while (tx === 1'b0) tick();
                end else begin
                    e       = sb.pop_front();
                    errs    = 0;
                    aborted = 1'b0;
                    got     = 16'd0;
                    nb      = 1 + e.n + (has_par(e.pmode) ? 1 : 0) + (e.two ? 2 : 1);
                    for (int b = 0; b < nb; b++) begin
                        eb = frame_bit(e, b);
                        for (int c = 0; c < e.div; c++) begin
                            if (rst !== 1'b1) aborted = 1'b1;
                            if (!aborted) begin
                                if (tx !== eb) errs++;
                                if (c == 0 && b >= 1 && b <= e.n) got[b-1] = tx;
                                if (c == 0 && b == e.n + 1 && has_par(e.pmode)) last_par = tx;
                            end
                            tick();
                        end
                    end
                    if (!aborted) begin
                        mask = (17'd1 << e.n) - 17'd1;
                        check("frame_bits", errs, 0);
                        check("frame_data", {16'd0, got}, {16'd0, e.data & mask[15:0]});
                        check("frame_done_pulse", {31'd0, frame_done}, 32'd1);
                        if (b2b_chk && sb.size() != 0) check("b2b_gap", {31'd0, tx}, 32'd0);
                    end
                end
                mon_busy = 1'b0;
            end else begin
                tick();
            end
        end
    end

    vec_t vt[9];

    initial begin : main
        int cnt;
        int lows;
        vt[0] = '{16'd4, 5'd8,  2'b00, 1'b0, 16'h00A5, 40, 1'b0};
        vt[1] = '{16'd2, 5'd7,  2'b01, 1'b0, 16'h0003, 20, 1'b0};
        vt[2] = '{16'd2, 5'd7,  2'b10, 1'b0, 16'h0003, 20, 1'b1};
        vt[3] = '{16'd2, 5'd16, 2'b01, 1'b0, 16'hFFFF, 38, 1'b0};
        vt[4] = '{16'd0, 5'd5,  2'b00, 1'b1, 16'h0015, 8,  1'b0};
        vt[5] = '{16'd3, 5'd0,  2'b10, 1'b0, 16'h0001, 12, 1'b0};
        vt[6] = '{16'd1, 5'd31, 2'b00, 1'b1, 16'h1234, 19, 1'b0};
        vt[7] = '{16'd5, 5'd3,  2'b01, 1'b1, 16'h0006, 35, 1'b0};
        vt[8] = '{16'd2, 5'd8,  2'b11, 1'b0, 16'h005A, 20, 1'b0};

        rst = 1'b1; wr_en = 1'b0; data_in = 16'd0; clk_div = 16'd4;
        bits_per_word = 5'd8; parity_mode = 2'b00; two_stop = 1'b0;
        #2;
        rst = 1'b0;
        repeat (3) tick();
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_level", {28'd0, level}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        rst = 1'b1;
        repeat (2) tick();

        // Table of single-frame vectors: length, pulse, busy drop and parity bit.
        for (int i = 0; i < 9; i++) begin
            clk_div       = vt[i].div;
            bits_per_word = vt[i].bpw;
            parity_mode   = vt[i].pmode;
            two_stop      = vt[i].two;
            write_word(vt[i].data, 1'b1);
            check("empty_after_write", {31'd0, empty}, 32'd0);
            cnt = 0;
            while (frame_done !== 1'b1 && cnt < 2000) begin
                tick();
                cnt++;
            end
            check("frame_len", cnt - 1, vt[i].exp_len);
            tick();
            check("frame_done_once", {31'd0, frame_done}, 32'd0);
            check("busy_after_frame", {31'd0, busy}, 32'd0);
            check("empty_after_frame", {31'd0, empty}, 32'd1);
            if (has_par(vt[i].pmode)) check("parity_bit", {31'd0, last_par}, {31'd0, vt[i].exp_par});
            repeat (3) tick();
        end

        // FIFO fill and overflow behind a slow serialiser.
        clk_div = 16'd20; bits_per_word = 5'd8; parity_mode = 2'b00; two_stop = 1'b0;
        for (int i = 0; i < 10; i++) begin
            write_word(16'((i * 29 + 7) & 8'hFF), (i < 9) ? 1'b1 : 1'b0);
            if (i == 8) begin
                check("fill_level", {28'd0, level}, 32'd8);
                check("fill_full", {31'd0, full}, 32'd1);
                check("fill_no_ovf", {31'd0, overflow}, 32'd0);
            end
            if (i == 9) begin
                check("ovf_pulse", {31'd0, overflow}, 32'd1);
                check("ovf_level", {28'd0, level}, 32'd8);
            end
        end
        tick();
        check("ovf_single", {31'd0, overflow}, 32'd0);
        b2b_chk = 1'b1;
        wait_drain(9 * 200 + 200);
        b2b_chk = 1'b0;
        tick();
        check("fill_end_empty", {31'd0, empty}, 32'd1);
        check("fill_end_busy", {31'd0, busy}, 32'd0);
        repeat (3) tick();

        // Push coinciding with pop at level 3; 20 words exercise pointer wrap.
        clk_div = 16'd2; bits_per_word = 5'd8;
        for (int k = 0; k < 4; k++) write_word(16'((k * 37 + 5) & 8'hFF), 1'b1);
        check("wrap_level_pre", {28'd0, level}, 32'd3);
        repeat (17) tick();
        for (int k = 4; k < 20; k++) begin
            write_word(16'((k * 37 + 5) & 8'hFF), 1'b1);
            check("push_pop_level", {28'd0, level}, 32'd3);
            if (k < 19) repeat (19) tick();
        end
        b2b_chk = 1'b1;
        wait_drain(1000);
        b2b_chk = 1'b0;
        tick();
        check("wrap_end_empty", {31'd0, empty}, 32'd1);
        repeat (3) tick();

        // Reset asserted during data bit 3 with a second word queued.
        clk_div = 16'd4; bits_per_word = 5'd8;
        write_word(16'h00F0, 1'b1);
        write_word(16'h0055, 1'b1);
        repeat (17) tick();
        rst = 1'b0;
        #2;
        check("mid_rst_tx", {31'd0, tx}, 32'd1);
        check("mid_rst_empty", {31'd0, empty}, 32'd1);
        check("mid_rst_level", {28'd0, level}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        sb.delete();
        repeat (3) tick();
        rst = 1'b1;
        lows = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (tx !== 1'b1) lows++;
        end
        check("post_rst_no_frame", lows, 0);
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
